// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction queue.
// Direction encoding: 00 RIGHT, 01 LEFT, 10 UP, 11 DOWN; opposite = LSB inverted.
// Key candidate priority: UP > LEFT > DOWN > RIGHT.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Selected key direction plus a flag saying whether any key fired.
    typedef struct packed {
        logic vld;
        dir_t d;
    } cand_t;

    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    function automatic cand_t dir_from_keys(input logic up, input logic down,
                                            input logic left, input logic right);
        cand_t c;
        c.vld = up | down | left | right;
        if (up)        c.d = DIR_UP;
        else if (left) c.d = DIR_LEFT;
        else if (down) c.d = DIR_DOWN;
        else           c.d = DIR_RIGHT;
        return c;
    endfunction

endpackage

// File: rtl/snake_dir_chan.sv
// One player: validates key pulses into turns, buffers them, commits one per move tick.
// Latency: key edge -> pending+1 next cycle; head -> dir on the next move_tick edge.
// Backpressure: none upstream; a valid turn arriving at a full queue (no pop) is dropped and flagged.
// Ports: clk, rst (sync, active-high), clear, move_tick, up/down/left/right key pulses;
//        dir (committed direction), pending (occupancy 0..QUEUE_DEPTH), drop (registered pulse).
// Build option: SNAKE_DIR_BYPASS_EN lets a turn go straight to dir when the queue is empty on a tick.
module snake_dir_chan
    import snake_pkg::*;
#(
    parameter int   QUEUE_DEPTH = 2,
    parameter dir_t INIT_DIR    = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       move_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output dir_t       dir,
    output logic [3:0] pending,
    output logic       drop
);

    localparam int            PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [3:0]    DEPTH = 4'(QUEUE_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(QUEUE_DEPTH - 1);

    dir_t          mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    dir_t          tail;      // copy of the newest queued entry, used as the validation reference

    cand_t cand;
    dir_t  ref_dir;
    logic  accept;
    logic  full;
    logic  pop;
    logic  push;
    logic  byp;
    logic  drop_nxt;

    always_comb begin
        cand     = dir_from_keys(up, down, left, right);
        ref_dir  = (pending != 4'd0) ? tail : dir;
        accept   = cand.vld && (cand.d != ref_dir) && (cand.d != dir_opposite(ref_dir));
        full     = (pending == DEPTH);
        pop      = move_tick && (pending != 4'd0);
`ifdef SNAKE_DIR_BYPASS_EN
        byp      = accept && move_tick && (pending == 4'd0);
`else
        byp      = 1'b0;
`endif
        // A pop in the same cycle frees a slot, so a full queue still accepts.
        push     = accept && !byp && (!full || pop);
        drop_nxt = accept && full && !pop;
    end

    // Storage needs no reset: occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cand.d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            dir     <= INIT_DIR;
            pending <= 4'd0;
            drop    <= 1'b0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            tail    <= INIT_DIR;
        end else begin
            drop    <= drop_nxt;
            pending <= pending + {3'd0, push} - {3'd0, pop};
            if (push) begin
                tail   <= cand.d;
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end else if (byp) begin
                dir <= cand.d;
            end
        end
    end

endmodule

// File: rtl/snake_dir_queue.sv
// Multi-player buffered snake direction register; one independent channel per player.
// Latency: key -> pending after one edge; queued turn -> dir on a later move_tick edge.
// Backpressure: none; per-player drop pulses when a valid turn finds its queue full.
// Ports: clk, rst (sync, active-high), clear, move_tick, up/down/left/right_pulse[NUM_PLAYERS];
//        dir[2p+1:2p], pending[4p+3:4p], drop[p] per player p.
// Build option: SNAKE_DIR_BYPASS_EN (handled inside each channel).
module snake_dir_queue
    import snake_pkg::*;
#(
    parameter int         NUM_PLAYERS = 2,
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] INIT_DIR    = 2'b00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     move_tick,
    input  logic [NUM_PLAYERS-1:0]   up_pulse,
    input  logic [NUM_PLAYERS-1:0]   down_pulse,
    input  logic [NUM_PLAYERS-1:0]   left_pulse,
    input  logic [NUM_PLAYERS-1:0]   right_pulse,
    output logic [2*NUM_PLAYERS-1:0] dir,
    output logic [4*NUM_PLAYERS-1:0] pending,
    output logic [NUM_PLAYERS-1:0]   drop
);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_chan
        dir_t       ch_dir;
        logic [3:0] ch_pending;
        logic       ch_drop;

        snake_dir_chan #(
            .QUEUE_DEPTH (QUEUE_DEPTH),
            .INIT_DIR    (dir_t'(INIT_DIR))
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .move_tick (move_tick),
            .up        (up_pulse[p]),
            .down      (down_pulse[p]),
            .left      (left_pulse[p]),
            .right     (right_pulse[p]),
            .dir       (ch_dir),
            .pending   (ch_pending),
            .drop      (ch_drop)
        );

        assign dir[2*p +: 2]     = ch_dir;
        assign pending[4*p +: 4] = ch_pending;
        assign drop[p]           = ch_drop;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue (2 players, depth 2, INIT_DIR RIGHT).
// The driver pushes the hand-computed post-edge state into a scoreboard;
// a monitor pops it one step after each edge and compares dir/pending/drop.
module tb_snake_dir_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] up_pulse = 2'b00;
    logic [1:0] down_pulse = 2'b00;
    logic [1:0] left_pulse = 2'b00;
    logic [1:0] right_pulse = 2'b00;
    logic [3:0] dir;
    logic [7:0] pending;
    logic [1:0] drop;

    int checks = 0;
    int failures = 0;
    int step_id = 0;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  dir;
        logic [7:0]  pend;
        logic [1:0]  drop;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    snake_dir_queue #(
        .NUM_PLAYERS (2),
        .QUEUE_DEPTH (2),
        .INIT_DIR    (2'b00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .move_tick   (move_tick),
        .up_pulse    (up_pulse),
        .down_pulse  (down_pulse),
        .left_pulse  (left_pulse),
        .right_pulse (right_pulse),
        .dir         (dir),
        .pending     (pending),
        .drop        (drop)
    );

    // Apply one cycle of stimulus and record the state expected after the next edge.
    task automatic step(input logic r, input logic c, input logic t,
                        input logic [1:0] u, input logic [1:0] d,
                        input logic [1:0] l, input logic [1:0] rt,
                        input logic [3:0] e_dir, input logic [7:0] e_pend,
                        input logic [1:0] e_drop);
        exp_t e;
        @(negedge clk);
        rst         = r;
        clear       = c;
        move_tick   = t;
        up_pulse    = u;
        down_pulse  = d;
        left_pulse  = l;
        right_pulse = rt;
        step_id++;
        e.id   = 16'(step_id);
        e.dir  = e_dir;
        e.pend = e_pend;
        e.drop = e_drop;
        sb.push_back(e);
    endtask

    // Monitor: the outputs are valid every cycle after an edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (dir !== e.dir) begin
                    failures++;
                    $display("FAIL dir step=%0d got=%b exp=%b", e.id, dir, e.dir);
                end
                checks++;
                if (pending !== e.pend) begin
                    failures++;
                    $display("FAIL pending step=%0d got=%h exp=%h", e.id, pending, e.pend);
                end
                checks++;
                if (drop !== e.drop) begin
                    failures++;
                    $display("FAIL drop step=%0d got=%b exp=%b", e.id, drop, e.drop);
                end
            end
        end
    end

    initial begin
        //    rst   clr   tick  up     down   left   right   dir      pending  drop
        // reset, then DOWN and commit
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 8'h00, 2'b00);
        // clear back to RIGHT; reversal and redundant requests are rejected
        step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 8'h00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 8'h00, 2'b00);
        // UP then LEFT buffered, two ticks commit them in order
        step(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 8'h02, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0010, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 8'h00, 2'b00);
        // player 1: UP, LEFT, DOWN with no tick -> third is dropped
        step(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0001, 8'h10, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0001, 8'h20, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001, 8'h20, 2'b10);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001, 8'h20, 2'b00);
        // full queue, push + tick together: accepted, no drop, occupancy held
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 4'b1001, 8'h20, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0101, 8'h10, 2'b00);
        // clear mid-queue overrides a same-cycle key
        step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);
        // player 1 to UP, then P0 UP and P1 LEFT together
        step(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h10, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1000, 8'h00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 4'b1000, 8'h11, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0110, 8'h00, 2'b00);
        // priority: LEFT beats DOWN and RIGHT for player 0 (now UP)
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0110, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0101, 8'h00, 2'b00);
        // empty queue: DOWN key and tick in the same cycle
`ifdef SNAKE_DIR_BYPASS_EN
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0111, 8'h00, 2'b00);
`else
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0101, 8'h01, 2'b00);
`endif
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111, 8'h00, 2'b00);
        // push+pop on a one-entry queue validates against the queued tail (LEFT), not dir (DOWN)
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0111, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0101, 8'h01, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111, 8'h00, 2'b00);
        // reset overrides keys
        step(1'b1, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);
        step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 8'h00, 2'b00);

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
